snes_pad_responder: RTL and testbench

- Controller-side end of the SNES pad serial protocol: the responder that answers the console-side poller sharing the snes_clk / data_latch / serial_data wires.
- Samples a 12-bit button vector on each latch pulse, then shifts it out one bit per snes_clk rising edge, active-low, B first.
- Used as a synthesizable pad emulator, so board-to-board links and the closed-loop bench can drive the existing SNES poller without a physical controller.
- snes_clk and data_latch are asynchronous to clk and are synchronized internally.

---
 rtl/snes_pkg.sv | 35 +++
 rtl/snes_sync_edge.sv | 31 +++
 rtl/snes_pad_responder.sv | 103 ++++++++++
 tb/tb_snes_pad_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// snes_pkg: shared state encoding, frame geometry and button map for the SNES pad responder
package snes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } snes_state_t;

    localparam int SNES_FRAME_BITS  = 16;
    localparam int SNES_BUTTON_BITS = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Trailing four bits of a standard pad always read released
    localparam logic [3:0] SNES_PAD_ID = 4'b1111;

    // Wire-level frame: active-low buttons, B in bit 0, pad ID on top
    function automatic logic [SNES_FRAME_BITS-1:0] snes_frame(input logic [SNES_BUTTON_BITS-1:0] b);
        return {SNES_PAD_ID, ~b};
    endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// snes_sync_edge: multi-stage synchronizer for an async pin with one-cycle rise/fall pulses
module snes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the pin through the synchronizer, then keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: pad-side SNES serial responder that latches buttons and shifts them out active-low
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2400000,
    parameter int TO_WIDTH       = 22
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        snes_clk,
    input  logic                        data_latch,
    input  logic [SNES_BUTTON_BITS-1:0] buttons,
    output logic                        serial_data,
    output logic                        frame_done,
    output logic                        busy
);

    snes_state_t                state;
    logic [3:0]                 bit_idx;
    logic [SNES_FRAME_BITS-1:0] shift_reg;
    logic [TO_WIDTH-1:0]        to_cnt;
    logic                       clk_level, clk_rise, clk_fall;
    logic                       latch_level, latch_rise, latch_fall;
    logic                       any_edge, timed_out;
    logic                       unused_levels;
    logic [SNES_FRAME_BITS-1:0] frame;

    snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (snes_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (data_latch),
        .level    (latch_level),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    assign unused_levels = clk_level ^ latch_level;
    assign frame         = snes_frame(buttons);
    assign any_edge      = clk_rise | clk_fall | latch_rise | latch_fall;
    assign timed_out     = to_cnt == TO_WIDTH'(TIMEOUT_CYCLES);

    // Frame FSM with saturating inactivity timeout; latch_rise restarts from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            serial_data <= 1'b1;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            bit_idx     <= '0;
            shift_reg   <= '1;
            to_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            to_cnt     <= any_edge ? '0 : (state != IDLE && !timed_out) ? to_cnt + 1'b1 : to_cnt;
            if (latch_rise) begin
                state       <= LATCH;
                shift_reg   <= frame;
                bit_idx     <= '0;
                serial_data <= frame[0];
                busy        <= 1'b1;
            end else if (state != IDLE && timed_out && !any_edge) begin
                state       <= IDLE;
                serial_data <= 1'b1;
                busy        <= 1'b0;
            end else begin
                case (state)
                    LATCH: begin
                        shift_reg   <= frame;
                        serial_data <= frame[0];
                        if (latch_fall) state <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            if (bit_idx == 4'(SNES_FRAME_BITS - 1)) begin
                                state       <= DONE;
                                serial_data <= 1'b0;
                                frame_done  <= 1'b1;
                                busy        <= 1'b0;
                            end else begin
                                bit_idx     <= bit_idx + 1'b1;
                                shift_reg   <= {1'b1, shift_reg[SNES_FRAME_BITS-1:1]};
                                serial_data <= shift_reg[1];
                            end
                        end
                    end
                    DONE:    serial_data <= 1'b0;
                    default: serial_data <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: directed frames checked against a frame-level pad model and literal poller views
module tb_snes_pad_responder;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snes_clk = 1'b1;
    logic        data_latch = 1'b0;
    logic [11:0] buttons = 12'h000;
    logic        serial_data, frame_done, busy;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    always #10 clk = ~clk;

    snes_pad_responder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .snes_clk    (snes_clk),
        .data_latch  (data_latch),
        .buttons     (buttons),
        .serial_data (serial_data),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input logic [11:0] b);
        buttons    = b;
        data_latch = 1'b1;
        tick(12);
        data_latch = 1'b0;
        tick(8);
    endtask

    // Poller view: sample serial_data at each rising snes_clk pin edge
    task automatic shift_bits(input int n, output logic [15:0] seen);
        seen = '1;
        for (int i = 0; i < n; i++) begin
            snes_clk = 1'b0;
            tick(8);
            seen[i]  = serial_data;
            snes_clk = 1'b1;
            tick(8);
        end
    endtask

    // Frame-level model: pins seen two clocks late, frame word + count of bits already delivered
    int          m_mode;
    int          m_cnt;
    int          m_quiet;
    logic [15:0] m_word;
    logic [2:0]  hc, hl;
    logic        exp_sd, exp_fd, exp_busy;
    bit          model_live = 1'b0;

    always @(posedge clk) begin : model
        logic lr, lf, cr, cf, any_e, to_hit;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_quiet = 0; m_word = '1;
            hc = '0; hl = '0;
            exp_sd = 1'b1; exp_fd = 1'b0; exp_busy = 1'b0;
            model_live = 1'b1;
        end else begin
            lr = hl[1] & ~hl[2];
            lf = ~hl[1] & hl[2];
            cr = hc[1] & ~hc[2];
            cf = ~hc[1] & hc[2];
            any_e  = lr | lf | cr | cf;
            to_hit = (m_mode != 0) && (m_quiet == TO) && !any_e;
            m_quiet = any_e ? 0 : (m_mode != 0 && m_quiet < TO) ? m_quiet + 1 : m_quiet;
            exp_fd = 1'b0;
            if (lr) begin
                m_mode = 1; m_word = {4'hF, ~buttons}; m_cnt = 0;
            end else if (to_hit) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                m_word = {4'hF, ~buttons};
                if (lf) m_mode = 2;
            end else if (m_mode == 2 && cr) begin
                m_cnt++;
                if (m_cnt == 16) begin
                    m_mode = 3;
                    exp_fd = 1'b1;
                end
            end
            exp_sd   = (m_mode == 0) ? 1'b1 : (m_mode == 3) ? 1'b0 : m_word[m_cnt];
            exp_busy = (m_mode == 1) || (m_mode == 2);
            hc = {hc[1:0], snes_clk};
            hl = {hl[1:0], data_latch};
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            check("cyc_serial_data", serial_data, exp_sd);
            check("cyc_frame_done", frame_done, exp_fd);
            check("cyc_busy", busy, exp_busy);
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        logic [15:0] seen;
        tick(3);
        reset = 1'b0;
        tick(4);
        check("reset_serial", serial_data, 1);
        check("reset_busy", busy, 0);

        repeat (100) begin
            snes_clk = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 4));
        end
        snes_clk = 1'b1;
        tick(6);
        check("idle_serial", serial_data, 1);
        check("idle_busy", busy, 0);

        do_latch(12'h001);
        check("latch_busy", busy, 1);
        shift_bits(16, seen);
        tick(4);
        check("frame_b_bits", seen, 16'hFFFE);
        check("frame_b_done_cnt", fd_cnt, 1);
        check("done_serial", serial_data, 0);
        shift_bits(2, seen);
        check("done_extra_serial", serial_data, 0);
        check("done_extra_cnt", fd_cnt, 1);

        do_latch(12'hA5C);
        shift_bits(16, seen);
        check("poll_a5c", seen, 16'hF5A3);
        do_latch(12'h3FF);
        shift_bits(16, seen);
        check("poll_3ff", seen, 16'hFC00);
        tick(4);
        check("poll_done_cnt", fd_cnt, 3);

        buttons    = 12'h000;
        data_latch = 1'b1;
        tick(6);
        buttons = 12'h800;
        tick(6);
        data_latch = 1'b0;
        tick(4);
        buttons = 12'hFFF;
        tick(4);
        shift_bits(16, seen);
        check("late_change_bits", seen, 16'hF7FF);
        tick(4);
        check("late_done_cnt", fd_cnt, 4);

        do_latch(12'h001);
        shift_bits(5, seen);
        check("relatch_pre_bits", seen[4:0], 5'b11110);
        do_latch(12'h021);
        check("relatch_first", serial_data, 0);
        check("relatch_no_done", fd_cnt, 4);
        shift_bits(16, seen);
        check("relatch_bits", seen, 16'hFFDE);
        tick(4);
        check("relatch_done_cnt", fd_cnt, 5);

        do_latch(12'h0F0);
        shift_bits(3, seen);
        check("to_busy_before", busy, 1);
        tick(TO + 10);
        check("to_serial", serial_data, 1);
        check("to_busy", busy, 0);
        check("to_no_done", fd_cnt, 5);

        do_latch(12'h000);
        shift_bits(4, seen);
        reset = 1'b1;
        tick(1);
        check("rst_mid_serial", serial_data, 1);
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        tick(8);
        check("rst_wait_serial", serial_data, 1);
        do_latch(12'hFFF);
        shift_bits(16, seen);
        check("post_rst_bits", seen, 16'hF000);
        tick(4);
        check("post_rst_done_cnt", fd_cnt, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
